// File: rtl/dram_miss_requester_pkg.sv
// Shared types and widths for the cache-side DRAM miss requester.
package dram_miss_requester_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned HALF_W = 11;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_FILL_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/dram_miss_requester_if.sv
// Miss/fill handshake, DRAM request bundle, statistics and error flags of the requester.
interface dram_miss_requester_if;
    import dram_miss_requester_pkg::*;

    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_read_addr;
    logic [HALF_W-1:0] miss_victim_upper;
    logic              miss_victim_dirty;
    logic [LINE_W-1:0] miss_victim_lane;
    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] fill_lane;
    logic [HALF_W-1:0] addr_req_read_dram_side_dram;
    logic [HALF_W-1:0] addr_req_write_dram_side_dram;
    logic [HALF_W-1:0] addr_req_common_side_dram;
    logic [LINE_W-1:0] lane_from_cache_to_dram_side_dram;
    logic              dram_controller_entry_dirty_side_dram;
    logic              dram_controller_req_read_pulse_side_dram;
    logic              dram_controller_ack_read_pulse_side_dram;
    logic [LINE_W-1:0] lane_from_dram_to_cache_side_dram;
    logic [STAT_W-1:0] stat_miss_count;
    logic [STAT_W-1:0] stat_prefetch_hits;
    logic [STAT_W-1:0] stat_max_latency;
    logic              err_timeout;
    logic              err_spurious_ack;

    modport master (
        input  miss_valid, miss_read_addr, miss_victim_upper, miss_victim_dirty, miss_victim_lane,
        input  fill_ready, dram_controller_ack_read_pulse_side_dram, lane_from_dram_to_cache_side_dram,
        output miss_ready, fill_valid, fill_addr, fill_lane,
        output addr_req_read_dram_side_dram, addr_req_write_dram_side_dram, addr_req_common_side_dram,
        output lane_from_cache_to_dram_side_dram, dram_controller_entry_dirty_side_dram,
        output dram_controller_req_read_pulse_side_dram,
        output stat_miss_count, stat_prefetch_hits, stat_max_latency, err_timeout, err_spurious_ack
    );

    modport slave (
        output miss_valid, miss_read_addr, miss_victim_upper, miss_victim_dirty, miss_victim_lane,
        output fill_ready, dram_controller_ack_read_pulse_side_dram, lane_from_dram_to_cache_side_dram,
        input  miss_ready, fill_valid, fill_addr, fill_lane,
        input  addr_req_read_dram_side_dram, addr_req_write_dram_side_dram, addr_req_common_side_dram,
        input  lane_from_cache_to_dram_side_dram, dram_controller_entry_dirty_side_dram,
        input  dram_controller_req_read_pulse_side_dram,
        input  stat_miss_count, stat_prefetch_hits, stat_max_latency, err_timeout, err_spurious_ack
    );

endinterface

// File: rtl/dram_miss_requester_sat_latency_counter.sv
// Saturating pulse-to-ack latency counter with a running maximum.
module sat_latency_counter
    import dram_miss_requester_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              max_upd,
    output logic [STAT_W-1:0] count,
    output logic [STAT_W-1:0] max_val
);

    localparam logic [STAT_W-1:0] SAT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            max_val <= '0;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (inc && (count != SAT_MAX)) begin
                count <= count + STAT_W'(1);
            end
            // max tracks the latency of the cycle the strobe arrives in
            if (max_upd && (count > max_val)) begin
                max_val <= count;
            end
        end
    end

endmodule

// File: rtl/dram_miss_requester.sv
// Cache-side requester: one outstanding line read (plus optional victim) to dram_controller,
// fill hand-back to the cache, latency/prefetch statistics and sticky protocol errors.
module dram_miss_requester
    import dram_miss_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES   = 2047,
    parameter int unsigned PREFETCH_LAT_MAX = 3
) (
    input  logic                 main_clk,
    input  logic                 main_rst,
    dram_miss_requester_if.master bus
);

    state_e            state;
    logic [STAT_W-1:0] latency;
    logic              accept;
    logic              ack;

    assign ack    = bus.dram_controller_ack_read_pulse_side_dram;
    assign accept = (state == ST_IDLE) && bus.miss_valid && bus.miss_ready;

    sat_latency_counter u_lat (
        .clk     (main_clk),
        .rst     (main_rst),
        .clr     (accept),
        .inc     (state == ST_WAIT_ACK),
        .max_upd ((state == ST_WAIT_ACK) && ack),
        .count   (latency),
        .max_val (bus.stat_max_latency)
    );

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state                                     <= ST_IDLE;
            bus.miss_ready                            <= 1'b0;
            bus.fill_valid                            <= 1'b0;
            bus.fill_addr                             <= '0;
            bus.fill_lane                             <= '0;
            bus.addr_req_read_dram_side_dram          <= '0;
            bus.addr_req_write_dram_side_dram         <= '0;
            bus.addr_req_common_side_dram             <= '0;
            bus.lane_from_cache_to_dram_side_dram     <= '0;
            bus.dram_controller_entry_dirty_side_dram <= 1'b0;
            bus.dram_controller_req_read_pulse_side_dram <= 1'b0;
            bus.stat_miss_count                       <= '0;
            bus.stat_prefetch_hits                    <= '0;
            bus.err_timeout                           <= 1'b0;
            bus.err_spurious_ack                      <= 1'b0;
        end else begin
            bus.dram_controller_req_read_pulse_side_dram <= 1'b0;
            if (ack && (state != ST_WAIT_ACK)) begin
                bus.err_spurious_ack <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // bundle stays frozen until the next accepted miss
                        bus.addr_req_read_dram_side_dram          <= bus.miss_read_addr[ADDR_W-1:HALF_W];
                        bus.addr_req_common_side_dram             <= bus.miss_read_addr[HALF_W-1:0];
                        bus.addr_req_write_dram_side_dram         <= bus.miss_victim_upper;
                        bus.lane_from_cache_to_dram_side_dram     <= bus.miss_victim_lane;
                        bus.dram_controller_entry_dirty_side_dram <= bus.miss_victim_dirty;
                        bus.dram_controller_req_read_pulse_side_dram <= 1'b1;
                        bus.stat_miss_count <= bus.stat_miss_count + STAT_W'(1);
                        bus.miss_ready      <= 1'b0;
                        state               <= ST_WAIT_ACK;
                    end else begin
                        bus.miss_ready <= 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        bus.fill_lane  <= bus.lane_from_dram_to_cache_side_dram;
                        bus.fill_addr  <= {bus.addr_req_read_dram_side_dram, bus.addr_req_common_side_dram};
                        bus.fill_valid <= 1'b1;
                        if (latency <= STAT_W'(PREFETCH_LAT_MAX)) begin
                            bus.stat_prefetch_hits <= bus.stat_prefetch_hits + STAT_W'(1);
                        end
                        state <= ST_FILL_HOLD;
                    end else if (latency == STAT_W'(TIMEOUT_CYCLES)) begin
                        bus.err_timeout <= 1'b1;
                    end
                end
                ST_FILL_HOLD: begin
                    if (bus.fill_ready) begin
                        bus.fill_valid <= 1'b0;
                        bus.miss_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_miss_requester.sv
// Directed bench for dram_miss_requester: transaction-level reference model plus literal spot checks.
module tb_dram_miss_requester;
    import dram_miss_requester_pkg::*;

    localparam int unsigned TMO = 2047;
    localparam int unsigned PF  = 3;

    logic main_clk = 1'b0;
    logic main_rst = 1'b1;

    dram_miss_requester_if bus ();

    dram_miss_requester #(
        .TIMEOUT_CYCLES   (TMO),
        .PREFETCH_LAT_MAX (PF)
    ) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .bus      (bus)
    );

    always #5 main_clk = ~main_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a miss is either outstanding, being held as a fill, or absent.
    logic              m_ready = 1'b0, m_pulse = 1'b0, m_fv = 1'b0, m_dirty = 1'b0;
    logic              m_errt = 1'b0, m_errs = 1'b0;
    logic [21:0]       m_fill_addr = '0, m_req_addr = '0;
    logic [10:0]       m_wr = '0;
    logic [127:0]      m_fill_lane = '0, m_vlane = '0;
    int                m_cnt = 0, m_hits = 0, m_max = 0;
    int                m_cyc = 0, m_pulse_cyc = 0;
    bit                m_waiting = 1'b0, m_holding = 1'b0;

    always @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            m_ready = 0; m_pulse = 0; m_fv = 0; m_dirty = 0; m_errt = 0; m_errs = 0;
            m_fill_addr = '0; m_req_addr = '0; m_wr = '0; m_fill_lane = '0; m_vlane = '0;
            m_cnt = 0; m_hits = 0; m_max = 0; m_cyc = 0; m_pulse_cyc = 0;
            m_waiting = 0; m_holding = 0;
        end else begin
            int lat;
            lat = m_cyc - m_pulse_cyc;
            if (lat > 65535) lat = 65535;
            m_pulse = 1'b0;
            if (bus.dram_controller_ack_read_pulse_side_dram && !m_waiting) m_errs = 1'b1;
            if (m_waiting) begin
                if (bus.dram_controller_ack_read_pulse_side_dram) begin
                    m_fill_lane = bus.lane_from_dram_to_cache_side_dram;
                    m_fill_addr = m_req_addr;
                    m_fv = 1'b1;
                    if (lat > m_max) m_max = lat;
                    if (lat <= int'(PF)) m_hits = (m_hits + 1) % 65536;
                    m_waiting = 0;
                    m_holding = 1;
                end else if (lat == int'(TMO)) begin
                    m_errt = 1'b1;
                end
            end else if (m_holding) begin
                if (bus.fill_ready) begin
                    m_fv = 1'b0;
                    m_holding = 0;
                    m_ready = 1'b1;
                end
            end else if (bus.miss_valid && m_ready) begin
                m_req_addr  = bus.miss_read_addr;
                m_wr        = bus.miss_victim_upper;
                m_dirty     = bus.miss_victim_dirty;
                m_vlane     = bus.miss_victim_lane;
                m_pulse     = 1'b1;
                m_pulse_cyc = m_cyc + 1;
                m_cnt       = (m_cnt + 1) % 65536;
                m_waiting   = 1;
                m_ready     = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
            m_cyc++;
        end
    end

    always @(negedge main_clk) begin
        chk("miss_ready", 128'(bus.miss_ready), 128'(m_ready));
        chk("req_pulse", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(m_pulse));
        chk("fill_valid", 128'(bus.fill_valid), 128'(m_fv));
        chk("fill_addr", 128'(bus.fill_addr), 128'(m_fill_addr));
        chk("fill_lane", bus.fill_lane, m_fill_lane);
        chk("addr_read", 128'(bus.addr_req_read_dram_side_dram), 128'(m_req_addr[21:11]));
        chk("addr_common", 128'(bus.addr_req_common_side_dram), 128'(m_req_addr[10:0]));
        chk("addr_write", 128'(bus.addr_req_write_dram_side_dram), 128'(m_wr));
        chk("victim_lane", bus.lane_from_cache_to_dram_side_dram, m_vlane);
        chk("victim_dirty", 128'(bus.dram_controller_entry_dirty_side_dram), 128'(m_dirty));
        chk("stat_miss_count", 128'(bus.stat_miss_count), 128'(16'(m_cnt)));
        chk("stat_prefetch_hits", 128'(bus.stat_prefetch_hits), 128'(16'(m_hits)));
        chk("stat_max_latency", 128'(bus.stat_max_latency), 128'(16'(m_max)));
        chk("err_timeout", 128'(bus.err_timeout), 128'(m_errt));
        chk("err_spurious_ack", 128'(bus.err_spurious_ack), 128'(m_errs));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge main_clk);
        #1;
    endtask

    // Present a miss and return in the pulse cycle.
    task automatic do_miss(input logic [21:0] a, input logic [10:0] vu, input logic d, input logic [127:0] l);
        int w;
        bus.miss_read_addr    = a;
        bus.miss_victim_upper = vu;
        bus.miss_victim_dirty = d;
        bus.miss_victim_lane  = l;
        bus.miss_valid        = 1'b1;
        w = 0;
        while (bus.miss_ready !== 1'b1 && w < 8) begin
            tick(1);
            w++;
        end
        chk("miss_ready_wait", 128'(bus.miss_ready), 128'(1));
        tick(1);
        bus.miss_valid = 1'b0;
        chk("pulse_after_accept", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(1));
    endtask

    // From the pulse cycle, ack at the given latency; returns one cycle after the ack.
    task automatic ack_at(input int lat, input logic [127:0] l);
        tick(lat);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram        = l;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        bus.lane_from_dram_to_cache_side_dram        = '0;
    endtask

    task automatic release_fill();
        bus.fill_ready = 1'b1;
        tick(1);
        bus.fill_ready = 1'b0;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [127:0] lane_a5, lane_v, lane_b, lane_c;
        int ph;
        lane_a5 = {16{8'hA5}};
        lane_v  = {4{32'hDEADBEEF}};
        lane_b  = {8{16'h1357}};
        lane_c  = {2{64'h0123_4567_89AB_CDEF}};

        bus.miss_valid = 0; bus.miss_read_addr = '0; bus.miss_victim_upper = '0;
        bus.miss_victim_dirty = 0; bus.miss_victim_lane = '0; bus.fill_ready = 0;
        bus.dram_controller_ack_read_pulse_side_dram = 0;
        bus.lane_from_dram_to_cache_side_dram = '0;

        // reset state
        tick(3);
        chk("rst_miss_ready", 128'(bus.miss_ready), 128'(0));
        chk("rst_fill_valid", 128'(bus.fill_valid), 128'(0));
        chk("rst_miss_count", 128'(bus.stat_miss_count), 128'(0));
        main_rst = 1'b0;
        tick(1);
        chk("idle_ready", 128'(bus.miss_ready), 128'(1));

        // cold clean miss, latency 13
        do_miss(22'h12345, 11'h000, 1'b0, '0);
        ack_at(13, lane_a5);
        chk("cold_fill_valid", 128'(bus.fill_valid), 128'(1));
        chk("cold_fill_lane", bus.fill_lane, lane_a5);
        chk("cold_fill_addr", 128'(bus.fill_addr), 128'(22'h12345));
        chk("cold_max_lat", 128'(bus.stat_max_latency), 128'(13));
        chk("cold_pf_hits", 128'(bus.stat_prefetch_hits), 128'(0));
        release_fill();

        // prefetch hit at latency 2: fill visible three cycles after the pulse
        do_miss(22'h0ABCD, 11'h055, 1'b0, '0);
        tick(2);
        chk("pf_no_fill_yet", 128'(bus.fill_valid), 128'(0));
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram = lane_b;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        chk("pf_fill_at_t3", 128'(bus.fill_valid), 128'(1));
        chk("pf_hits", 128'(bus.stat_prefetch_hits), 128'(1));
        release_fill();

        // dirty victim: bundle stable and a one-cycle pulse through ack at latency 5
        do_miss(22'h2AAAA, 11'h7FF, 1'b1, lane_v);
        ph = 0;
        for (int k = 0; k < 5; k++) begin
            chk("dirty_wr_addr", 128'(bus.addr_req_write_dram_side_dram), 128'(11'h7FF));
            chk("dirty_lane", bus.lane_from_cache_to_dram_side_dram, lane_v);
            ph += int'(bus.dram_controller_req_read_pulse_side_dram);
            tick(1);
        end
        chk("dirty_wr_addr_ack", 128'(bus.addr_req_write_dram_side_dram), 128'(11'h7FF));
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram = lane_v;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        chk("pulse_width", 128'(ph), 128'(1));

        // backpressure for 20 cycles, then release with a miss waiting
        tick(20);
        chk("bp_fill_valid", 128'(bus.fill_valid), 128'(1));
        chk("bp_miss_ready", 128'(bus.miss_ready), 128'(0));
        chk("bp_fill_addr", 128'(bus.fill_addr), 128'(22'h2AAAA));
        bus.miss_read_addr = 22'h01234; bus.miss_victim_upper = 11'h321;
        bus.miss_victim_dirty = 1'b0; bus.miss_victim_lane = lane_c;
        bus.miss_valid = 1'b1;
        bus.fill_ready = 1'b1;
        tick(1);
        bus.fill_ready = 1'b0;
        chk("rel_idle_ready", 128'(bus.miss_ready), 128'(1));
        chk("rel_no_pulse", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(0));
        tick(1);
        bus.miss_valid = 1'b0;
        chk("rel_next_pulse", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(1));
        ack_at(4, lane_c);
        chk("lat4_not_prefetch", 128'(bus.stat_prefetch_hits), 128'(1));
        chk("miss_count_4", 128'(bus.stat_miss_count), 128'(4));
        release_fill();

        // timeout: flag after TMO cycles without ack, still waiting
        do_miss(22'h155555, 11'h0F0, 1'b0, '0);
        tick(TMO);
        chk("tmo_not_yet", 128'(bus.err_timeout), 128'(0));
        tick(1);
        chk("tmo_set", 128'(bus.err_timeout), 128'(1));
        chk("tmo_still_waiting", 128'(bus.miss_ready), 128'(0));
        chk("tmo_no_fill", 128'(bus.fill_valid), 128'(0));
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram = lane_b;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        chk("tmo_late_fill", 128'(bus.fill_valid), 128'(1));
        chk("tmo_max_lat", 128'(bus.stat_max_latency), 128'(2048));
        release_fill();

        // spurious ack in IDLE
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram = lane_a5;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        chk("spur_flag", 128'(bus.err_spurious_ack), 128'(1));
        chk("spur_no_fill", 128'(bus.fill_valid), 128'(0));
        tick(1);
        chk("spur_still_idle", 128'(bus.miss_ready), 128'(1));

        // reset while waiting for ack
        do_miss(22'h3C3C3, 11'h123, 1'b1, lane_v);
        tick(3);
        main_rst = 1'b1;
        #1;
        chk("rstw_pulse", 128'(bus.dram_controller_req_read_pulse_side_dram), 128'(0));
        chk("rstw_dirty", 128'(bus.dram_controller_entry_dirty_side_dram), 128'(0));
        chk("rstw_lane", bus.lane_from_cache_to_dram_side_dram, 128'(0));
        chk("rstw_count", 128'(bus.stat_miss_count), 128'(0));
        chk("rstw_errs", 128'(bus.err_spurious_ack), 128'(0));
        tick(1);
        main_rst = 1'b0;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b1;
        bus.lane_from_dram_to_cache_side_dram = lane_c;
        tick(1);
        bus.dram_controller_ack_read_pulse_side_dram = 1'b0;
        chk("rstw_spur", 128'(bus.err_spurious_ack), 128'(1));
        chk("rstw_tmo", 128'(bus.err_timeout), 128'(0));
        chk("rstw_no_fill", 128'(bus.fill_valid), 128'(0));
        chk("rstw_max", 128'(bus.stat_max_latency), 128'(0));
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
